// File: rtl/instr_load_sequencer.sv
// rtl/instr_load_sequencer.sv - boot/reload sequencer that streams instruction words into cpu imem
//
// Purpose:
//   Accepts a valid/ready stream of 32-bit instruction words and writes each one into
//   instruction memory through the cpu initialize port. The cpu is held in reset while
//   loading and for RST_HOLD further cycles, and is then released to run.
//   Flow: IDLE -> LOAD -> HOLD -> RUN, and RUN -> LOAD on start.
//
// Optional feature:
//   LOAD_CHECKSUM_EN - when defined, adds a checksum output carrying the XOR of every
//   accepted word of the current load.
//
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   start                           begin a load (acted on only in IDLE or RUN)
//   load_valid/load_data/load_last  instruction stream input
//   load_ready                      stream ready (high throughout LOAD)
//   initialize                      one-cycle imem write strobe
//   instruction_initialize_data     word to write
//   instruction_initialize_address  byte address to write
//   cpu_rst                         reset to the cpu
//   busy, done                      state is LOAD/HOLD, state is RUN
//   words_loaded                    beats accepted in the current or last load
//   err_overflow                    sticky: NUM_WORDS reached without load_last
//   checksum                        (LOAD_CHECKSUM_EN only) XOR of accepted words
module instr_load_sequencer #(
  parameter int          NUM_WORDS = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          RST_HOLD  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        initialize,
  output logic [31:0] instruction_initialize_data,
  output logic [31:0] instruction_initialize_address,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_loaded,
  output logic        err_overflow
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  localparam logic [15:0] LAST_IDX  = 16'(NUM_WORDS - 1);
  localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD - 1);

  state_t      state, state_next;
  logic        accept;
  logic        clear;
  logic [31:0] hold_cnt;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          clear      = 1'b1;
        end
      end
      LOAD: begin
        if (load_valid) begin
          accept = 1'b1;
          // Leave on the tagged last beat, or when the word budget is used up.
          if (load_last || (words_loaded == LAST_IDX)) state_next = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) state_next = RUN;
      end
      RUN: begin
        if (start) begin
          state_next = LOAD;
          clear      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign load_ready = (state == LOAD);
  assign busy       = (state == LOAD) || (state == HOLD);
  assign done       = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                          <= IDLE;
      initialize                     <= 1'b0;
      instruction_initialize_data    <= 32'h0;
      instruction_initialize_address <= 32'h0;
      cpu_rst                        <= 1'b1;
      words_loaded                   <= 16'h0;
      err_overflow                   <= 1'b0;
      hold_cnt                       <= 32'h0;
    end else begin
      state      <= state_next;
      initialize <= accept;
      // Registered from the next state so cpu_rst rises together with LOAD entry
      // and falls exactly when RUN begins.
      cpu_rst    <= (state_next != RUN);
      hold_cnt   <= (state == HOLD) ? hold_cnt + 32'd1 : 32'h0;
      if (clear) begin
        words_loaded <= 16'h0;
        err_overflow <= 1'b0;
      end
      if (accept) begin
        instruction_initialize_data    <= load_data;
        instruction_initialize_address <= BASE_ADDR + {14'h0, words_loaded, 2'b00};
        words_loaded                   <= words_loaded + 16'd1;
        if (!load_last && (words_loaded == LAST_IDX)) err_overflow <= 1'b1;
      end
    end
  end

`ifdef LOAD_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      checksum <= 32'h0;
    end else if (accept) begin
      checksum <= checksum ^ load_data;
    end
  end
`endif

endmodule

// File: tb/tb_instr_load_sequencer.sv
// tb/tb_instr_load_sequencer.sv - scoreboard bench for instr_load_sequencer
module tb_instr_load_sequencer;

  localparam int          NUM_WORDS = 4;
  localparam logic [31:0] BASE_ADDR = 32'h0;
  localparam int          RST_HOLD  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = 32'h0;
  logic        load_last = 1'b0;
  logic        load_ready, initialize, cpu_rst, busy, done, err_overflow;
  logic [31:0] instruction_initialize_data, instruction_initialize_address;
  logic [15:0] words_loaded;
`ifdef LOAD_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  always #5 clk = ~clk;

  instr_load_sequencer #(
    .NUM_WORDS(NUM_WORDS), .BASE_ADDR(BASE_ADDR), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .initialize(initialize),
    .instruction_initialize_data(instruction_initialize_data),
    .instruction_initialize_address(instruction_initialize_address),
    .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .words_loaded(words_loaded), .err_overflow(err_overflow)
`ifdef LOAD_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // Reference model: phase 0 idle, 1 loading, 2 holding, 3 running.
  int          phase = 0;
  int          n_words = 0;
  int          hold_left = 0;
  bit          ovf = 1'b0;
  logic [31:0] csum = 32'h0;
  logic [63:0] exp_q[$];
  bit          exp_strobe = 1'b0;
  bit          armed = 1'b0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and advance the model to the state after the next edge.
  task automatic drive(input bit r, input bit s, input bit v, input logic [31:0] d, input bit l);
    @(negedge clk);
    rst = r; start = s; load_valid = v; load_data = d; load_last = l;
    exp_strobe = 1'b0;
    if (r) begin
      phase = 0; n_words = 0; ovf = 1'b0; csum = 32'h0;
      exp_q.delete();
    end else begin
      case (phase)
        0, 3: if (s) begin
          phase = 1; n_words = 0; ovf = 1'b0; csum = 32'h0;
        end
        1: if (v) begin
          exp_q.push_back({BASE_ADDR + 32'(4 * n_words), d});
          exp_strobe = 1'b1;
          csum = csum ^ d;
          n_words++;
          if (l || n_words == NUM_WORDS) begin
            phase = 2; hold_left = RST_HOLD; ovf = !l;
          end
        end
        2: begin
          hold_left--;
          if (hold_left == 0) phase = 3;
        end
        default: phase = 0;
      endcase
    end
    armed = 1'b1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitor: samples just after every active edge and compares against the model.
  always @(posedge clk) begin
    #1;
    if (armed) begin
      logic [63:0] e;
      chk("initialize", 32'(initialize), 32'(exp_strobe));
      if (initialize) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("init_addr", instruction_initialize_address, e[63:32]);
          chk("init_data", instruction_initialize_data, e[31:0]);
          chk("rst_during_strobe", 32'(cpu_rst), 32'h1);
        end
      end
      chk("cpu_rst", 32'(cpu_rst), 32'(phase != 3));
      chk("load_ready", 32'(load_ready), 32'(phase == 1));
      chk("busy", 32'(busy), 32'(phase == 1 || phase == 2));
      chk("done", 32'(done), 32'(phase == 3));
      chk("words_loaded", 32'(words_loaded), 32'(n_words));
      chk("err_overflow", 32'(err_overflow), 32'(ovf));
`ifdef LOAD_CHECKSUM_EN
      chk("checksum", checksum, csum);
`endif
    end
  end

  initial begin
    // Reset, then idle.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(5);
    // Three back-to-back words, last on the third.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h20010005, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h20020003, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h00221820, 1'b1);
    idle(RST_HOLD + 2);
    // Overflow: six beats, no last.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b1, 32'h1000 + 32'(i), 1'b0);
    idle(RST_HOLD + 2);
    // Gapped valid, last on the second accepted beat.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'hA0A0A0A0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'hB0B0B0B0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(RST_HOLD + 2);
    // Reload from RUN, single word; then reset in the middle of a load.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'hAC010000, 1'b1);
    idle(RST_HOLD + 2);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'h22222222, 1'b0);
    idle(4);
    // Complementary halves; checksum all-ones, then reload clears it.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h0000FFFF, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF0000, 1'b1);
    idle(RST_HOLD + 2);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(2);
    // Random traffic, including start in LOAD/HOLD and valid outside LOAD.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
            $urandom_range(0, 1) == 1, $urandom, ($urandom_range(0, 3) == 0));
    end
    idle(RST_HOLD + 2);
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) chk("pending_strobes", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
